// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter: size codes, arbitration
// modes and default bus geometry.
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int DEF_NUM_CH  = 2;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MAX_OUT = 4;

    // Channel id width; a single channel still needs one bit of storage.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Channel-side and memory-side SRAM-like buses around the arbiter.
// slave = the arbiter's view, master = the surrounding pipeline/bridge.
interface sram_like_arbiter_if
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [NUM_CH-1:0]            ch_req;
    logic [NUM_CH-1:0]            ch_wr;
    logic [2*NUM_CH-1:0]          ch_size;
    logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb;
    logic [ADDR_W*NUM_CH-1:0]     ch_addr;
    logic [DATA_W*NUM_CH-1:0]     ch_wdata;
    logic [NUM_CH-1:0]            ch_addr_ok;
    logic [NUM_CH-1:0]            ch_data_ok;
    logic [DATA_W-1:0]            ch_rdata;

    logic                         mem_req;
    logic                         mem_wr;
    logic [1:0]                   mem_size;
    logic [DATA_W/8-1:0]          mem_wstrb;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic                         mem_addr_ok;
    logic                         mem_data_ok;
    logic [DATA_W-1:0]            mem_rdata;

    modport slave (
        input  ch_req, ch_wr, ch_size, ch_wstrb, ch_addr, ch_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output ch_addr_ok, ch_data_ok, ch_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output ch_req, ch_wr, ch_size, ch_wstrb, ch_addr, ch_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  ch_addr_ok, ch_data_ok, ch_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sram_id_fifo.sv
// In-order FIFO of issuing-channel ids for accepted, not yet answered
// transactions. DEPTH must be a power of two so the pointers wrap for free.
module sram_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = DEF_MAX_OUT
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter: merges channel requests onto one memory port,
// tracks outstanding transactions and routes responses back in order.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_OUT  = DEF_MAX_OUT,
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic                           clk,
    input  logic                           resetn,
    sram_like_arbiter_if.slave             bus,
    output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt,
    output logic                           proto_err
);
    localparam int ID_W   = id_width(NUM_CH);
    localparam int STRB_W = DATA_W / 8;

    logic            lock;
    logic [ID_W-1:0] lock_id;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] head_id;
    logic            fifo_full;
    logic            fifo_empty;
    logic            mem_req_i;
    logic            hs;
    logic            pop;

    // Earlier loop iterations are overridden by later ones: fixed mode keeps the
    // highest requester, round-robin walks backwards so rr_ptr's nearest wins.
    always_comb begin
        grant = '0;
        if (lock) begin
            grant = lock_id;
        end else if (ARB_MODE == ARB_RR) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (bus.ch_req[(int'(rr_ptr) + k) % NUM_CH])
                    grant = ID_W'((int'(rr_ptr) + k) % NUM_CH);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.ch_req[i]) grant = ID_W'(i);
            end
        end
    end

    assign mem_req_i = ((|bus.ch_req) | lock) & ~fifo_full;
    assign hs        = mem_req_i & bus.mem_addr_ok;
    assign pop       = bus.mem_data_ok & ~fifo_empty;

    // Every output is forced quiet while reset is asserted.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_size   = '0;
        bus.mem_wstrb  = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.ch_addr_ok = '0;
        bus.ch_data_ok = '0;
        bus.ch_rdata   = '0;
        if (resetn) begin
            bus.mem_req   = mem_req_i;
            bus.mem_wr    = bus.ch_wr[grant];
            bus.mem_size  = bus.ch_size[grant*2 +: 2];
            bus.mem_wstrb = bus.ch_wstrb[grant*STRB_W +: STRB_W];
            bus.mem_addr  = bus.ch_addr[grant*ADDR_W +: ADDR_W];
            bus.mem_wdata = bus.ch_wdata[grant*DATA_W +: DATA_W];
            bus.ch_rdata  = bus.mem_rdata;
            if (hs)  bus.ch_addr_ok[grant]   = 1'b1;
            if (pop) bus.ch_data_ok[head_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock      <= 1'b0;
            lock_id   <= '0;
            rr_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (hs) begin
                lock <= 1'b0;
            end else if (mem_req_i) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end
            if (hs && (ARB_MODE == ARB_RR))
                rr_ptr <= ID_W'((int'(grant) + 1) % NUM_CH);
            // Emptiness is judged before any same-cycle push.
            if (bus.mem_data_ok && fifo_empty)
                proto_err <= 1'b1;
        end
    end

    sram_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs),
        .pop    (pop),
        .din    (grant),
        .dout   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (out_cnt)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a fixed-priority instance driven from a
// vector table plus hand-written sequences, and a round-robin instance.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h1000_0004;
    localparam logic [31:0] W0 = 32'h0000_AAAA;
    localparam logic [31:0] W1 = 32'h5555_0000;

    logic       clk;
    logic       resetn;
    logic [2:0] cnt_fx, cnt_rr;
    logic       err_fx, err_rr;
    int         n_pass;
    int         n_total;

    sram_like_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bf ();
    sram_like_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) br ();

    sram_like_arbiter #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .ARB_MODE(ARB_FIXED)
    ) dut_fx (
        .clk(clk), .resetn(resetn), .bus(bf), .out_cnt(cnt_fx), .proto_err(err_fx)
    );

    sram_like_arbiter #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .ARB_MODE(ARB_RR)
    ) dut_rr (
        .clk(clk), .resetn(resetn), .bus(br), .out_cnt(cnt_rr), .proto_err(err_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  req;
        logic        maok;
        logic        mdok;
        logic [31:0] rdata;
        logic        ereq;
        logic        eg;
        logic [1:0]  eaok;
        logic [1:0]  edok;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive_fx(input logic [1:0] req, input logic maok, input logic mdok,
                            input logic [31:0] rdata);
        bf.ch_req      = req;
        bf.mem_addr_ok = maok;
        bf.mem_data_ok = mdok;
        bf.mem_rdata   = rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_fx(2'b00, 1'b0, 1'b0, 32'h0);
        br.ch_req      = 2'b00;
        br.mem_addr_ok = 1'b0;
        br.mem_data_ok = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        resetn  = 1'b0;
        bf.ch_wr     = 2'b10;
        bf.ch_size   = {SIZE_H, SIZE_W};
        bf.ch_wstrb  = 8'h3F;
        bf.ch_addr   = {A1, A0};
        bf.ch_wdata  = {W1, W0};
        br.ch_wr     = 2'b10;
        br.ch_size   = {SIZE_H, SIZE_W};
        br.ch_wstrb  = 8'h3F;
        br.ch_addr   = {A1, A0};
        br.ch_wdata  = {W1, W0};
        br.mem_rdata = 32'h0;

        //          req    maok  mdok  rdata          ereq  eg    eaok   edok   ecnt
        vt[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 2'b00, 2'b00, 3'd0};
        vt[1]  = '{2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 2'b10, 2'b00, 3'd0};
        vt[2]  = '{2'b10, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 2'b00, 2'b00, 3'd1};
        vt[3]  = '{2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 2'b00, 2'b00, 3'd1};
        vt[4]  = '{2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 2'b00, 2'b00, 3'd1};
        vt[5]  = '{2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 2'b10, 2'b00, 3'd1};
        vt[6]  = '{2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 2'b01, 2'b00, 3'd2};
        vt[7]  = '{2'b01, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 2'b00, 2'b00, 3'd3};
        vt[8]  = '{2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 2'b00, 2'b00, 3'd3};
        vt[9]  = '{2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 2'b01, 2'b00, 3'd3};
        vt[10] = '{2'b10, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 2'b00, 2'b00, 3'd4};
        vt[11] = '{2'b10, 1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b1, 2'b00, 2'b10, 3'd4};
        vt[12] = '{2'b10, 1'b1, 1'b1, 32'hBBBB_0002, 1'b1, 1'b1, 2'b10, 2'b10, 3'd3};
        vt[13] = '{2'b00, 1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 2'b00, 2'b01, 3'd3};
        vt[14] = '{2'b00, 1'b0, 1'b1, 32'hDDDD_0004, 1'b0, 1'b0, 2'b00, 2'b01, 3'd2};
        vt[15] = '{2'b00, 1'b0, 1'b1, 32'hEEEE_0005, 1'b0, 1'b0, 2'b00, 2'b10, 3'd1};
        vt[16] = '{2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 2'b00, 2'b00, 3'd0};

        do_reset();

        // Fixed priority, lock and ordering driven from the table.
        for (int v = 0; v < 17; v++) begin
            drive_fx(vt[v].req, vt[v].maok, vt[v].mdok, vt[v].rdata);
            #1;
            chk($sformatf("v%0d mem_req", v), bf.mem_req, vt[v].ereq);
            chk($sformatf("v%0d ch_addr_ok", v), bf.ch_addr_ok, vt[v].eaok);
            chk($sformatf("v%0d ch_data_ok", v), bf.ch_data_ok, vt[v].edok);
            chk($sformatf("v%0d out_cnt", v), cnt_fx, vt[v].ecnt);
            chk($sformatf("v%0d proto_err", v), err_fx, 1'b0);
            if (vt[v].ereq) begin
                chk($sformatf("v%0d mem_addr", v), bf.mem_addr, vt[v].eg ? A1 : A0);
                chk($sformatf("v%0d mem_wdata", v), bf.mem_wdata, vt[v].eg ? W1 : W0);
                chk($sformatf("v%0d mem_wr", v), bf.mem_wr, vt[v].eg);
                chk($sformatf("v%0d mem_size", v), bf.mem_size, vt[v].eg ? 2'd1 : 2'd2);
            end
            if (vt[v].edok != 2'b00)
                chk($sformatf("v%0d ch_rdata", v), bf.ch_rdata, vt[v].rdata);
            step();
        end

        // Outstanding limit: ch0 issues five reads with no responses.
        do_reset();
        drive_fx(2'b01, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fill%0d addr_ok", i), bf.ch_addr_ok, 2'b01);
            chk($sformatf("fill%0d out_cnt", i), cnt_fx, 3'(i));
            step();
        end
        #1;
        chk("full mem_req", bf.mem_req, 1'b0);
        chk("full addr_ok", bf.ch_addr_ok, 2'b00);
        chk("full out_cnt", cnt_fx, 3'd4);
        step();
        drive_fx(2'b01, 1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("full resp data_ok", bf.ch_data_ok, 2'b01);
        chk("full resp rdata", bf.ch_rdata, 32'hDEAD_BEEF);
        chk("full resp addr_ok", bf.ch_addr_ok, 2'b00);
        step();
        drive_fx(2'b01, 1'b1, 1'b0, 32'h0);
        #1;
        chk("fifth addr_ok", bf.ch_addr_ok, 2'b01);
        chk("fifth out_cnt", cnt_fx, 3'd3);
        step();
        drive_fx(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        chk("after fifth out_cnt", cnt_fx, 3'd4);

        // Response while empty, including a same-cycle push.
        do_reset();
        drive_fx(2'b01, 1'b1, 1'b1, 32'h1234_5678);
        #1;
        chk("err addr_ok", bf.ch_addr_ok, 2'b01);
        chk("err data_ok", bf.ch_data_ok, 2'b00);
        chk("err before edge", err_fx, 1'b0);
        step();
        drive_fx(2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        chk("err set", err_fx, 1'b1);
        chk("err out_cnt", cnt_fx, 3'd1);
        step();
        chk("err sticky", err_fx, 1'b1);

        // Reset asserted mid-cycle while traffic is being driven.
        drive_fx(2'b11, 1'b1, 1'b1, 32'hFFFF_FFFF);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst mem_req", bf.mem_req, 1'b0);
        chk("rst addr_ok", bf.ch_addr_ok, 2'b00);
        chk("rst data_ok", bf.ch_data_ok, 2'b00);
        chk("rst mem_addr", bf.mem_addr, 32'h0);
        chk("rst ch_rdata", bf.ch_rdata, 32'h0);
        chk("rst out_cnt", cnt_fx, 3'd0);
        chk("rst proto_err", err_fx, 1'b0);
        step();

        // Round-robin: both channels request continuously from rr_ptr=0.
        do_reset();
        br.ch_req      = 2'b11;
        br.mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d addr_ok", i), br.ch_addr_ok, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d mem_addr", i), br.mem_addr, (i % 2 == 0) ? A0 : A1);
            step();
        end
        #1;
        chk("rr full mem_req", br.mem_req, 1'b0);
        chk("rr out_cnt", cnt_rr, 3'd4);
        br.ch_req      = 2'b00;
        br.mem_addr_ok = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
